cluster_mem_responder: RTL and testbench

- Memory-side responder for the RV cluster request interface.
- Accepts one request at a time from a cluster: instruction-line fetch, data-line load, store, page-table-entry read or page-table-entry write.
- Sequences each request as 32-bit beats on a simple req/ack DRAM port.
- Returns 128-bit lines or 32-bit PTE words with busy/done status; sits between the cluster and the DRAM controller.

---
 rtl/cluster_mem_responder_pkg.sv | 25 ++
 rtl/cluster_mem_responder_store_lane_align.sv | 38 +++
 rtl/cluster_mem_responder.sv | 190 +++++++++++++++++++
 tb/tb_cluster_mem_responder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cluster_mem_responder_pkg.sv
// Shared encodings for the cluster memory responder: request modes, store
// sizes, FSM states and line geometry.
package cluster_mem_responder_pkg;

    localparam logic [2:0] MC_IFETCH = 3'd1;
    localparam logic [2:0] MC_LOAD   = 3'd2;
    localparam logic [2:0] MC_STORE  = 3'd3;
    localparam logic [2:0] MC_PTE_RD = 3'd4;
    localparam logic [2:0] MC_PTE_WR = 3'd5;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int LINE_BEATS = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LINE   = 3'd1,
        ST_PTE_RD = 3'd2,
        ST_WR     = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/cluster_mem_responder_store_lane_align.sv
// Places right-aligned store data onto the byte lanes of a 32-bit DRAM word
// and flags sub-word stores that straddle their natural alignment.
module cluster_mem_responder_store_lane_align
    import cluster_mem_responder_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  wmask,
    output logic [31:0] lane_wdata,
    output logic        misaligned
);

    always_comb begin
        wmask      = 4'h0;
        lane_wdata = 32'h0;
        misaligned = 1'b0;
        case (size)
            SZ_B: begin
                wmask      = 4'b0001 << addr_lo;
                lane_wdata = {4{wdata[7:0]}};
            end
            SZ_H: begin
                wmask      = 4'b0011 << addr_lo;
                lane_wdata = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            SZ_W: begin
                wmask      = 4'hF;
                lane_wdata = wdata;
                misaligned = (addr_lo != 2'b00);
            end
            // The reserved size encoding is rejected by the caller.
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/cluster_mem_responder.sv
// Memory-side responder: serialises one cluster request at a time into
// 32-bit req/ack DRAM beats and returns lines / PTE words with done status.
module cluster_mem_responder
    import cluster_mem_responder_pkg::*;
#(
    parameter int          TIMEOUT   = 1023,
    parameter logic [31:0] DRAM_BASE = 32'h8000_0000
) (
    input  logic         CLK,
    input  logic         RST_X,
    input  logic         w_req,
    input  logic [2:0]   w_mode,
    input  logic [31:0]  w_iaddr,
    input  logic [31:0]  w_daddr,
    input  logic [31:0]  w_pte_addr,
    input  logic [31:0]  w_wdata,
    input  logic [31:0]  w_pte_wdata,
    input  logic [2:0]   w_ctrl,
    output logic         w_busy,
    output logic         w_done,
    output logic         w_err,
    output logic [127:0] w_insn_data,
    output logic [127:0] w_data_data,
    output logic [31:0]  w_dram_odata,
    output logic         w_is_dram_data,
    output logic         w_dram_req,
    output logic         w_dram_we,
    output logic [31:0]  w_dram_addr,
    output logic [31:0]  w_dram_wdata,
    output logic [3:0]   w_dram_wmask,
    input  logic         w_dram_ack,
    input  logic [31:0]  w_dram_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [2:0]       mode_q;
    logic [31:0]      addr_q;
    logic [1:0]       beat_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             err_q;
    logic [95:0]      line_q;

    logic        accept, bad_req, in_beat, issue, beat_ack, timeout_hit, last_beat;
    logic [31:0] req_addr;
    logic [3:0]  st_wmask;
    logic [31:0] st_wdata;
    logic        st_misaligned;
    logic        ctrl_unused;

    // w_ctrl[2] carries no meaning for this responder.
    assign ctrl_unused = w_ctrl[2];

    cluster_mem_responder_store_lane_align u_align (
        .size       (w_ctrl[1:0]),
        .addr_lo    (w_daddr[1:0]),
        .wdata      (w_wdata),
        .wmask      (st_wmask),
        .lane_wdata (st_wdata),
        .misaligned (st_misaligned)
    );

    assign in_beat     = (state_q == ST_LINE) || (state_q == ST_PTE_RD) || (state_q == ST_WR);
    assign accept      = (state_q == ST_IDLE) && w_req;
    assign issue       = in_beat && !w_dram_req;
    assign beat_ack    = w_dram_req && w_dram_ack;
    assign timeout_hit = w_dram_req && !w_dram_ack && (wait_cnt_q == CNT_W'(TIMEOUT - 1));
    assign last_beat   = (state_q != ST_LINE) || (beat_q == 2'(LINE_BEATS - 1));

    assign w_busy = in_beat;
    assign w_done = (state_q == ST_DONE);
    assign w_err  = (state_q == ST_DONE) && err_q;

    always_comb begin
        bad_req  = 1'b0;
        req_addr = w_daddr;
        case (w_mode)
            MC_IFETCH:            req_addr = w_iaddr;
            MC_LOAD:              req_addr = w_daddr;
            MC_STORE:             bad_req  = (w_ctrl[1:0] == 2'd3) || st_misaligned;
            MC_PTE_RD, MC_PTE_WR: req_addr = w_pte_addr;
            default:              bad_req  = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bad_req)
                        state_d = ST_DONE;
                    else if (w_mode == MC_IFETCH || w_mode == MC_LOAD)
                        state_d = ST_LINE;
                    else if (w_mode == MC_PTE_RD)
                        state_d = ST_PTE_RD;
                    else
                        state_d = ST_WR;
                end
            end
            ST_LINE, ST_PTE_RD, ST_WR: begin
                if ((beat_ack && last_beat) || timeout_hit)
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            mode_q         <= 3'd0;
            addr_q         <= 32'h0;
            beat_q         <= 2'd0;
            wait_cnt_q     <= '0;
            err_q          <= 1'b0;
            line_q         <= 96'h0;
            w_insn_data    <= 128'h0;
            w_data_data    <= 128'h0;
            w_dram_odata   <= 32'h0;
            w_is_dram_data <= 1'b0;
            w_dram_req     <= 1'b0;
            w_dram_we      <= 1'b0;
            w_dram_addr    <= 32'h0;
            w_dram_wdata   <= 32'h0;
            w_dram_wmask   <= 4'h0;
        end else begin
            if (accept) begin
                mode_q     <= w_mode;
                addr_q     <= req_addr;
                beat_q     <= 2'd0;
                wait_cnt_q <= '0;
                err_q      <= bad_req;
                w_dram_we  <= (w_mode == MC_STORE) || (w_mode == MC_PTE_WR);
                // Write lanes are fixed at capture so they stay stable for the whole beat.
                if (w_mode == MC_STORE) begin
                    w_dram_wdata <= st_wdata;
                    w_dram_wmask <= st_wmask;
                end else if (w_mode == MC_PTE_WR) begin
                    w_dram_wdata <= w_pte_wdata;
                    w_dram_wmask <= 4'hF;
                end else begin
                    w_dram_wdata <= 32'h0;
                    w_dram_wmask <= 4'h0;
                end
            end

            if (issue) begin
                w_dram_req  <= 1'b1;
                w_dram_addr <= (state_q == ST_LINE) ? {addr_q[31:4], beat_q, 2'b00}
                                                    : {addr_q[31:2], 2'b00};
                wait_cnt_q  <= '0;
            end else if (beat_ack) begin
                wait_cnt_q <= '0;
                if (state_q == ST_LINE && !last_beat) begin
                    for (int k = 0; k < LINE_BEATS - 1; k++)
                        if (beat_q == 2'(k))
                            line_q[32*k +: 32] <= w_dram_rdata;
                    beat_q      <= beat_q + 2'd1;
                    w_dram_addr <= {addr_q[31:4], beat_q + 2'd1, 2'b00};
                end else begin
                    w_dram_req <= 1'b0;
                    if (state_q == ST_LINE && mode_q == MC_IFETCH) begin
                        w_insn_data <= {w_dram_rdata, line_q};
                    end else if (state_q == ST_LINE) begin
                        w_data_data    <= {w_dram_rdata, line_q};
                        w_is_dram_data <= (addr_q >= DRAM_BASE);
                    end else if (state_q == ST_PTE_RD) begin
                        w_dram_odata <= w_dram_rdata;
                    end
                end
            end else if (timeout_hit) begin
                // Abandon the beat; any partial line in line_q is simply never committed.
                w_dram_req <= 1'b0;
                err_q      <= 1'b1;
            end else if (w_dram_req) begin
                wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cluster_mem_responder.sv
// Scoreboard bench for cluster_mem_responder: expected DRAM beats and
// completion results are queued by the stimulus and checked by a monitor.
module tb_cluster_mem_responder;

    logic         CLK = 1'b0;
    logic         RST_X = 1'b0;
    logic         w_req = 1'b0;
    logic [2:0]   w_mode = 3'd0;
    logic [31:0]  w_iaddr = 32'h0, w_daddr = 32'h0, w_pte_addr = 32'h0;
    logic [31:0]  w_wdata = 32'h0, w_pte_wdata = 32'h0;
    logic [2:0]   w_ctrl = 3'd0;
    logic         w_busy, w_done, w_err, w_is_dram_data;
    logic [127:0] w_insn_data, w_data_data;
    logic [31:0]  w_dram_odata, w_dram_addr, w_dram_wdata, w_dram_rdata;
    logic         w_dram_req, w_dram_we, w_dram_ack;
    logic [3:0]   w_dram_wmask;

    int   ack_delay = 0;
    int   wait_ctr = 0;
    logic rdata_from_addr = 1'b1;
    logic [31:0] rdata_const = 32'h0;

    int total = 0;
    int bad = 0;

    cluster_mem_responder #(.TIMEOUT(15), .DRAM_BASE(32'h8000_0000)) dut (
        .CLK(CLK), .RST_X(RST_X), .w_req(w_req), .w_mode(w_mode),
        .w_iaddr(w_iaddr), .w_daddr(w_daddr), .w_pte_addr(w_pte_addr),
        .w_wdata(w_wdata), .w_pte_wdata(w_pte_wdata), .w_ctrl(w_ctrl),
        .w_busy(w_busy), .w_done(w_done), .w_err(w_err),
        .w_insn_data(w_insn_data), .w_data_data(w_data_data),
        .w_dram_odata(w_dram_odata), .w_is_dram_data(w_is_dram_data),
        .w_dram_req(w_dram_req), .w_dram_we(w_dram_we), .w_dram_addr(w_dram_addr),
        .w_dram_wdata(w_dram_wdata), .w_dram_wmask(w_dram_wmask),
        .w_dram_ack(w_dram_ack), .w_dram_rdata(w_dram_rdata)
    );

    always #5 CLK = ~CLK;

    // DRAM model: ack once the beat has waited ack_delay cycles (negative = never).
    assign w_dram_ack   = w_dram_req && (ack_delay >= 0) && (wait_ctr >= ack_delay);
    assign w_dram_rdata = rdata_from_addr ? w_dram_addr : rdata_const;
    always @(posedge CLK) wait_ctr <= (w_dram_req && !w_dram_ack) ? wait_ctr + 1 : 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } beat_t;

    typedef struct {
        logic         err;
        logic [127:0] insn;
        logic [127:0] data;
        logic [31:0]  odata;
        logic         is_dram;
    } resp_t;

    beat_t exp_beats[$];
    resp_t exp_resp[$];
    beat_t mb;
    resp_t mr;

    logic [127:0] m_insn = 128'h0, m_data = 128'h0;
    logic [31:0]  m_odata = 32'h0;
    logic         m_isdram = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] a, input logic we, input logic [31:0] d, input logic [3:0] m);
        beat_t b;
        b.addr = a; b.we = we; b.wdata = d; b.wmask = m;
        exp_beats.push_back(b);
    endtask

    task automatic push_resp(input logic err);
        resp_t r;
        r.err = err; r.insn = m_insn; r.data = m_data; r.odata = m_odata; r.is_dram = m_isdram;
        exp_resp.push_back(r);
    endtask

    task automatic push_line(input logic [31:0] base);
        for (int k = 0; k < 4; k++) push_beat(base + 32'(4 * k), 1'b0, 32'h0, 4'h0);
    endtask

    // Drives one request for a single cycle; returns at the negedge of the following cycle.
    task automatic send(input logic [2:0] mode, input logic [31:0] ia, input logic [31:0] da,
                        input logic [31:0] pa, input logic [31:0] wd, input logic [31:0] pwd,
                        input logic [2:0] ctrl);
        @(negedge CLK);
        w_mode = mode; w_iaddr = ia; w_daddr = da; w_pte_addr = pa;
        w_wdata = wd; w_pte_wdata = pwd; w_ctrl = ctrl; w_req = 1'b1;
        @(negedge CLK);
        w_req = 1'b0;
    endtask

    // lat = cycles from the request cycle to the w_done cycle; reqc = cycles with w_dram_req high.
    task automatic wait_done(output int lat, output int reqc);
        lat = 1; reqc = 0;
        while (!w_done && lat < 200) begin
            if (w_dram_req) reqc++;
            @(negedge CLK);
            lat++;
        end
        check("done_seen", {127'h0, w_done}, 128'h1);
    endtask

    // Monitor: pops and compares expectations whenever the DUT presents a beat or a completion.
    initial forever begin
        @(negedge CLK);
        if (RST_X) begin
            if (w_dram_req && w_dram_ack) begin
                if (exp_beats.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_beat: got addr %h expected none", w_dram_addr);
                end else begin
                    mb = exp_beats.pop_front();
                    check("beat_addr", {96'h0, w_dram_addr}, {96'h0, mb.addr});
                    check("beat_we", {127'h0, w_dram_we}, {127'h0, mb.we});
                    if (mb.we) begin
                        check("beat_wdata", {96'h0, w_dram_wdata}, {96'h0, mb.wdata});
                        check("beat_wmask", {124'h0, w_dram_wmask}, {124'h0, mb.wmask});
                    end
                end
            end
            if (w_done) begin
                if (exp_resp.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got err %0b expected none", w_err);
                end else begin
                    mr = exp_resp.pop_front();
                    check("resp_err", {127'h0, w_err}, {127'h0, mr.err});
                    check("resp_busy", {127'h0, w_busy}, 128'h0);
                    check("resp_insn", w_insn_data, mr.insn);
                    check("resp_data", w_data_data, mr.data);
                    check("resp_odata", {96'h0, w_dram_odata}, {96'h0, mr.odata});
                    check("resp_is_dram", {127'h0, w_is_dram_data}, {127'h0, mr.is_dram});
                end
            end
        end
    end

    initial begin
        int lat, reqc, n;

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_busy", {127'h0, w_busy}, 128'h0);
        check("rst_done", {127'h0, w_done}, 128'h0);
        check("rst_err", {127'h0, w_err}, 128'h0);
        check("rst_dram_req", {127'h0, w_dram_req}, 128'h0);
        check("rst_insn", w_insn_data, 128'h0);
        check("rst_data", w_data_data, 128'h0);
        check("rst_odata", {96'h0, w_dram_odata}, 128'h0);
        check("rst_dram_addr", {96'h0, w_dram_addr}, 128'h0);
        check("rst_wmask", {124'h0, w_dram_wmask}, 128'h0);
        RST_X = 1'b1;
        repeat (2) @(negedge CLK);

        // Ifetch of a full line, ack every cycle, rdata mirrors the address
        ack_delay = 0; rdata_from_addr = 1'b1;
        push_line(32'h8000_0010);
        m_insn = 128'h8000001C_80000018_80000014_80000010;
        push_resp(1'b0);
        send(3'd1, 32'h8000_0014, 32'h0000_0F00, 32'h0000_0A00, 32'h0, 32'h0, 3'd0);
        check("ifetch_busy", {127'h0, w_busy}, 128'h1);
        wait_done(lat, reqc);
        check("ifetch_latency", 128'(lat), 128'd6);

        // Store byte 0xAB at ...03 (ctrl bit2 set, must be ignored)
        push_beat(32'h8000_0000, 1'b1, 32'hABAB_ABAB, 4'b1000);
        push_resp(1'b0);
        send(3'd3, 32'h0, 32'h8000_0003, 32'h0, 32'h0000_00AB, 32'h0, 3'b100);
        wait_done(lat, reqc);
        check("stb_latency", 128'(lat), 128'd3);

        // Misaligned half store: immediate error, no DRAM traffic
        push_resp(1'b1);
        send(3'd3, 32'h0, 32'h8000_0001, 32'h0, 32'h0000_1234, 32'h0, 3'd1);
        wait_done(lat, reqc);
        check("sth_mis_latency", 128'(lat), 128'd1);
        check("sth_mis_no_req", 128'(reqc), 128'd0);

        // Load with ack withheld: aborts after 15 waiting cycles, data line untouched
        ack_delay = -1;
        push_resp(1'b1);
        send(3'd2, 32'h0, 32'h8000_0040, 32'h0, 32'h0, 32'h0, 3'd0);
        wait_done(lat, reqc);
        check("timeout_req_cycles", 128'(reqc), 128'd15);
        check("timeout_req_low", {127'h0, w_dram_req}, 128'h0);

        // PTE read, ack after 3 waiting cycles; a request pulsed while busy is ignored
        ack_delay = 3; rdata_from_addr = 1'b0; rdata_const = 32'h2000_0CF1;
        push_beat(32'h8000_2004, 1'b0, 32'h0, 4'h0);
        m_odata = 32'h2000_0CF1;
        push_resp(1'b0);
        send(3'd4, 32'h0000_0300, 32'h0000_0400, 32'h8000_2004, 32'h0, 32'h0, 3'd0);
        @(negedge CLK);
        check("pte_busy", {127'h0, w_busy}, 128'h1);
        w_mode = 3'd1; w_iaddr = 32'h0000_0300; w_req = 1'b1;
        @(negedge CLK);
        w_req = 1'b0;
        wait_done(lat, reqc);

        // Load in DRAM space from a mid-line address
        ack_delay = 0; rdata_from_addr = 1'b1;
        push_line(32'h8000_0020);
        m_data = 128'h8000002C_80000028_80000024_80000020; m_isdram = 1'b1;
        push_resp(1'b0);
        send(3'd2, 32'h0, 32'h8000_002C, 32'h0, 32'h0, 32'h0, 3'd0);
        wait_done(lat, reqc);
        check("load_latency", 128'(lat), 128'd6);

        // Load just below DRAM_BASE
        push_line(32'h7FFF_FFF0);
        m_data = 128'h7FFFFFFC_7FFFFFF8_7FFFFFF4_7FFFFFF0; m_isdram = 1'b0;
        push_resp(1'b0);
        send(3'd2, 32'h0, 32'h7FFF_FFF8, 32'h0, 32'h0, 32'h0, 3'd0);
        wait_done(lat, reqc);

        // Store word, store half (upper lanes), PTE write
        push_beat(32'h0000_0108, 1'b1, 32'h1234_5678, 4'hF);
        push_resp(1'b0);
        send(3'd3, 32'h0, 32'h0000_0108, 32'h0, 32'h1234_5678, 32'h0, 3'd2);
        wait_done(lat, reqc);
        push_beat(32'h0000_0100, 1'b1, 32'hBEEF_BEEF, 4'b1100);
        push_resp(1'b0);
        send(3'd3, 32'h0, 32'h0000_0102, 32'h0, 32'hDEAD_BEEF, 32'h0, 3'd1);
        wait_done(lat, reqc);
        push_beat(32'h8000_3004, 1'b1, 32'hCAFE_F00D, 4'hF);
        push_resp(1'b0);
        send(3'd5, 32'h0, 32'h0000_0500, 32'h8000_3007, 32'h1111_1111, 32'hCAFE_F00D, 3'd0);
        wait_done(lat, reqc);

        // Illegal requests: mode 6, reserved size, misaligned word
        push_resp(1'b1);
        send(3'd6, 32'h0, 32'h0000_0100, 32'h0, 32'h0, 32'h0, 3'd0);
        wait_done(lat, reqc);
        check("mode6_no_req", 128'(reqc), 128'd0);
        push_resp(1'b1);
        send(3'd3, 32'h0, 32'h0000_0100, 32'h0, 32'h0, 32'h0, 3'd3);
        wait_done(lat, reqc);
        check("size3_latency", 128'(lat), 128'd1);
        push_resp(1'b1);
        send(3'd3, 32'h0, 32'h0000_0102, 32'h0, 32'h0, 32'h0, 3'd2);
        wait_done(lat, reqc);
        check("stw_mis_no_req", 128'(reqc), 128'd0);

        // Reset asserted while beat 2 of a load is pending
        ack_delay = 2;
        push_beat(32'h8000_0080, 1'b0, 32'h0, 4'h0);
        push_beat(32'h8000_0084, 1'b0, 32'h0, 4'h0);
        send(3'd2, 32'h0, 32'h8000_0088, 32'h0, 32'h0, 32'h0, 3'd0);
        n = 0; lat = 0;
        while (n < 2 && lat < 100) begin
            @(negedge CLK);
            lat++;
            if (w_dram_req && w_dram_ack) n++;
        end
        check("rst_mid_acks", 128'(n), 128'd2);
        @(negedge CLK);
        RST_X = 1'b0;
        #1;
        check("rst_mid_req", {127'h0, w_dram_req}, 128'h0);
        check("rst_mid_busy", {127'h0, w_busy}, 128'h0);
        repeat (2) @(negedge CLK);
        check("rst_mid_insn", w_insn_data, 128'h0);
        check("rst_mid_data", w_data_data, 128'h0);
        check("rst_mid_beats_left", 128'(exp_beats.size()), 128'd0);
        RST_X = 1'b1;
        m_insn = 128'h0; m_data = 128'h0; m_odata = 32'h0; m_isdram = 1'b0;
        @(negedge CLK);

        // Fresh ifetch after reset completes normally
        ack_delay = 0;
        push_line(32'h0000_0200);
        m_insn = 128'h0000020C_00000208_00000204_00000200;
        push_resp(1'b0);
        send(3'd1, 32'h0000_0200, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0);
        wait_done(lat, reqc);
        check("post_rst_latency", 128'(lat), 128'd6);

        repeat (3) @(negedge CLK);
        check("beats_drained", 128'(exp_beats.size()), 128'd0);
        check("resps_drained", 128'(exp_resp.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
